// File: rtl/aes128_pipe_flow_if.sv
// Request/response bundle for aes128_pipe_flow: keyed plaintext in, tagged ciphertext out.
// The DUT takes the slave side; the producer/consumer pair takes the master side.
interface aes128_pipe_flow_if #(
  parameter int TAG_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_key;
  logic [127:0]     in_pt;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_ct;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_key, in_pt, in_tag, out_ready,
    input  in_ready, out_valid, out_ct, out_tag
  );

  modport slave (
    input  in_valid, in_key, in_pt, in_tag, out_ready,
    output in_ready, out_valid, out_ct, out_tag
  );
endinterface

// File: rtl/aes128_pipe_flow.sv
// AES-128 encrypt pipeline with per-block key expansion, RPS rounds per stage and a
// credit-guarded first-word-fallthrough output FIFO that absorbs consumer stalls.
module aes128_pipe_flow #(
  parameter int TAG_W      = 16,
  parameter int RPS        = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  aes128_pipe_flow_if.slave                    bus,
  output logic                                 busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      occupancy,
  output logic [31:0]                          blk_count
);

  localparam int LAT    = 10 / RPS + 1;
  localparam int NSTAGE = LAT - 1;
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef struct packed {
    logic [127:0] st;
    logic [127:0] key;
  } blk_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input int rnd);
    case (rnd)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t;
    logic [31:0] n0, n1, n2, n3;
    t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Byte i of the state sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] rk,
                                            input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        t[4*c+w] = b[4*((c+w)%4)+w];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (last) begin
        r[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return r ^ rk;
  endfunction

  function automatic blk_t apply_rounds(input blk_t b, input int first);
    blk_t x;
    x = b;
    for (int j = 0; j < RPS; j++) begin
      x.key = next_key(x.key, rcon(first + j));
      x.st  = round_fn(x.st, x.key, (first + j) == 10);
    end
    return x;
  endfunction

  blk_t             r_blk [NSTAGE+1];
  logic [TAG_W-1:0] r_tag [NSTAGE+1];
  logic [NSTAGE:0]  r_vld;
  blk_t             w_nxt [1:NSTAGE];

  logic [TAG_W+127:0] r_mem [FIFO_DEPTH];
  logic [PTR_W:0]     r_wr_ptr;
  logic [PTR_W:0]     r_rd_ptr;
  logic [OCC_W-1:0]   r_occ;
  logic [31:0]        r_blk_cnt;

  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_pop;
  logic               w_wr;
  logic [TAG_W+127:0] w_head;

  for (genvar s = 1; s <= NSTAGE; s++) begin : g_round
    assign w_nxt[s] = apply_rounds(r_blk[s-1], (s - 1) * RPS + 1);
  end

  // Credits count everything accepted but not yet popped, so every block in the
  // pipeline already owns a FIFO slot and the pipeline itself never stalls.
  assign w_in_ready  = (r_occ < OCC_W'(FIFO_DEPTH));
  assign w_out_valid = (r_wr_ptr != r_rd_ptr);
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_wr        = r_vld[NSTAGE];
  assign w_head      = r_mem[r_rd_ptr[PTR_W-1:0]];

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_ct    = w_head[127:0];
  assign bus.out_tag   = w_head[TAG_W+127:128];
  assign busy          = (r_occ != '0);
  assign occupancy     = r_occ;
  assign blk_count     = r_blk_cnt;

  // NOTE: datapath stages and FIFO storage carry no reset; r_vld and the FIFO
  // pointers alone decide what is live, which keeps reset fan-out off the wide buses.
  always_ff @(posedge clk) begin
    r_blk[0] <= '{st: bus.in_pt ^ bus.in_key, key: bus.in_key};
    r_tag[0] <= bus.in_tag;
    for (int s = 1; s <= NSTAGE; s++) begin
      r_blk[s] <= w_nxt[s];
      r_tag[s] <= r_tag[s-1];
    end
    if (w_wr) r_mem[r_wr_ptr[PTR_W-1:0]] <= {r_tag[NSTAGE], r_blk[NSTAGE].st};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_blk_cnt <= '0;
    end else begin
      r_vld <= {r_vld[NSTAGE-1:0], w_accept};
      if (w_wr)  r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + (PTR_W+1)'(1);
        r_blk_cnt <= r_blk_cnt + 32'd1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
